ice_bus_scheduler: RTL

Sequences all traffic on the UART link between the FPGA and the ICE motor boards. It sits between the Avalon register bank and the frame transmitter of the link. It latches one-cycle control-mode and setpoint update triggers per motor so none are lost, and generates round-robin status polls at the programmed rate. It arbitrates these requests into one command at a time, then waits for the transmitter to finish the frame (or time out) before issuing the next.

---
 rtl/ice_bus_scheduler.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ice_bus_scheduler.sv
// ice_bus_scheduler: latches per-motor mode/setpoint triggers, generates
// round-robin status polls, and issues one frame command at a time to the
// UART frame transmitter, honouring tx_done, a frame timeout and an idle gap.
module ice_bus_scheduler #(
    parameter int unsigned NUMBER_OF_MOTORS = 6,
    parameter int unsigned CLOCK_FREQ_HZ    = 50_000_000,
    parameter int unsigned GAP_CYCLES       = 16,
    parameter int unsigned TIMEOUT_CYCLES   = 50_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        trigger_control_mode_update,
    input  logic        trigger_setpoint_update,
    input  logic [7:0]  motor_to_update,
    input  logic [31:0] status_update_frequency_Hz,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_type,
    output logic [7:0]  cmd_motor,
    input  logic        tx_done,
    output logic        busy,
    output logic [15:0] timeout_count,
    output logic [15:0] overrun_count,
    output logic [15:0] bad_motor_count
);
    localparam int unsigned N     = NUMBER_OF_MOTORS;
    localparam int unsigned ACC_W = 40;
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] TYPE_STATUS = 2'd0;
    localparam logic [1:0] TYPE_MODE   = 2'd1;
    localparam logic [1:0] TYPE_SP     = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   timer_q, timer_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [ACC_W-1:0]   acc_q, acc_d, inc, sum;
    logic [PTR_W-1:0]   poll_ptr_q;
    logic [N-1:0]       mode_pend_q, sp_pend_q, stat_pend_q;
    logic [N-1:0]       trig_onehot, ptr_onehot, grant_onehot;
    logic [N-1:0]       mode_clr, sp_clr, stat_clr, stat_live;
    logic [N-1:0]       mode_set, sp_set, stat_set;
    logic               trig_valid, poll_tick, poll_overrun, accept;
    logic               load_grant, timeout_hit, any_pend;
    logic [1:0]         arb_type, bad_inc;
    logic [7:0]         arb_motor;

    function automatic logic [7:0] lowest_index(input logic [N-1:0] vec);
        lowest_index = '0;
        for (int i = int'(N) - 1; i >= 0; i--)
            if (vec[i]) lowest_index = 8'(i);
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] add);
        logic [16:0] s;
        s = 17'(cnt) + 17'(add);
        sat_add = s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Poll-rate generator: fractional accumulator, one tick per CLOCK_FREQ_HZ of credit
    always_comb begin
        inc       = ACC_W'(status_update_frequency_Hz) * ACC_W'(N);
        sum       = acc_q + inc;
        acc_d     = sum;
        poll_tick = 1'b0;
        if (status_update_frequency_Hz == 32'd0) begin
            acc_d = '0;
        end else if (inc >= ACC_W'(CLOCK_FREQ_HZ)) begin
            acc_d     = '0;
            poll_tick = 1'b1;
        end else if (sum >= ACC_W'(CLOCK_FREQ_HZ)) begin
            acc_d     = sum - ACC_W'(CLOCK_FREQ_HZ);
            poll_tick = 1'b1;
        end
    end

    // One-hot decodes of trigger index, poll pointer and granted motor
    always_comb begin
        trig_onehot  = '0;
        ptr_onehot   = '0;
        grant_onehot = '0;
        for (int i = 0; i < int'(N); i++) begin
            trig_onehot[i]  = (motor_to_update == 8'(i));
            ptr_onehot[i]   = (poll_ptr_q == PTR_W'(i));
            grant_onehot[i] = (cmd_motor == 8'(i));
        end
    end

    // Pending-bit set/clear terms; a simultaneous set beats the clear
    always_comb begin
        trig_valid   = |trig_onehot;
        accept       = (state_q == S_ISSUE) && cmd_ready;
        mode_clr     = (accept && cmd_type == TYPE_MODE)   ? grant_onehot : '0;
        sp_clr       = (accept && cmd_type == TYPE_SP)     ? grant_onehot : '0;
        stat_clr     = (accept && cmd_type == TYPE_STATUS) ? grant_onehot : '0;
        mode_set     = trigger_control_mode_update ? trig_onehot : '0;
        sp_set       = trigger_setpoint_update     ? trig_onehot : '0;
        stat_live    = stat_pend_q & ~stat_clr;
        poll_overrun = poll_tick && |(stat_live & ptr_onehot);
        stat_set     = (poll_tick && !poll_overrun) ? ptr_onehot : '0;
        bad_inc      = 2'(trigger_control_mode_update & ~trig_valid)
                     + 2'(trigger_setpoint_update & ~trig_valid);
    end

    // Arbitration: mode before setpoint before status, lowest motor first
    always_comb begin
        any_pend  = |{mode_pend_q, sp_pend_q, stat_pend_q};
        arb_type  = TYPE_STATUS;
        arb_motor = lowest_index(stat_pend_q);
        if (|mode_pend_q) begin
            arb_type  = TYPE_MODE;
            arb_motor = lowest_index(mode_pend_q);
        end else if (|sp_pend_q) begin
            arb_type  = TYPE_SP;
            arb_motor = lowest_index(sp_pend_q);
        end
    end

    // Next-state logic for the command sequencer
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        load_grant  = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_pend) begin
                    load_grant = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end else if (timer_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    gap_d       = '0;
                    state_d     = S_GAP;
                end else begin
                    timer_d = timer_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else                                 gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and registered command outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            gap_q     <= '0;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_type  <= '0;
            cmd_motor <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            cmd_valid <= (state_d == S_ISSUE);
            busy      <= (state_d != S_IDLE);
            if (load_grant) begin
                cmd_type  <= arb_type;
                cmd_motor <= arb_motor;
            end
        end
    end

    // Pending bitmaps, poll accumulator and poll pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_pend_q <= '0;
            sp_pend_q   <= '0;
            stat_pend_q <= '0;
            acc_q       <= '0;
            poll_ptr_q  <= '0;
        end else begin
            mode_pend_q <= (mode_pend_q & ~mode_clr) | mode_set;
            sp_pend_q   <= (sp_pend_q & ~sp_clr) | sp_set;
            stat_pend_q <= stat_live | stat_set;
            acc_q       <= acc_d;
            if (poll_tick)
                poll_ptr_q <= (poll_ptr_q == PTR_W'(N - 1)) ? '0 : poll_ptr_q + PTR_W'(1);
        end
    end

    // Saturating event counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout_count   <= '0;
            overrun_count   <= '0;
            bad_motor_count <= '0;
        end else begin
            timeout_count   <= sat_add(timeout_count, 2'(timeout_hit));
            overrun_count   <= sat_add(overrun_count, 2'(poll_overrun));
            bad_motor_count <= sat_add(bad_motor_count, bad_inc);
        end
    end
endmodule
